// File: rtl/sync_ram_pkg.sv
// Shared types and constants for the multi-read-port synchronous RAM.
//   state_e     : clear sequencer states
//   rdw_mode_e  : same-address read-during-write behaviour
//   OUT_LAT_MAX : deepest read pipeline a port can build
package sync_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  typedef enum logic {
    RDW_OLD = 1'b0,
    RDW_NEW = 1'b1
  } rdw_mode_e;

  localparam int unsigned OUT_LAT_MAX = 2;

endpackage

// File: rtl/sync_ram_rd_port.sv
// One synchronous read port of sync_ram_mport.
//   clk_i, rst_i  : clock, async active-high reset
//   rd_en_i       : accepted read request (already gated by the clear FSM)
//   rd_addr_i     : read address
//   mem_word_i    : array word at rd_addr_i (0 when out of range)
//   wr_en_i       : accepted user write this cycle
//   wr_addr_i     : user write address
//   wr_data_i     : user write data
//   rd_data_o     : read data, holds its value between reads
//   rd_valid_o    : one-cycle strobe per accepted read
module sync_ram_rd_port
  import sync_ram_pkg::*;
#(
  parameter int unsigned WIDTH_P    = 8,
  parameter int unsigned DEPTH_P    = 16,
  parameter int unsigned RDW_MODE_P = 0,
  parameter int unsigned OUT_REG_P  = 0,
  parameter int unsigned AW_P       = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               rd_en_i,
  input  logic [AW_P-1:0]    rd_addr_i,
  input  logic [WIDTH_P-1:0] mem_word_i,
  input  logic               wr_en_i,
  input  logic [AW_P-1:0]    wr_addr_i,
  input  logic [WIDTH_P-1:0] wr_data_i,
  output logic [WIDTH_P-1:0] rd_data_o,
  output logic               rd_valid_o
);

  localparam logic [AW_P:0] DepthW   = (AW_P+1)'(DEPTH_P);
  localparam bit            BypassEn = (RDW_MODE_P == 32'(RDW_NEW));
  localparam int unsigned   LatC     = ((1 + OUT_REG_P) > OUT_LAT_MAX) ? OUT_LAT_MAX
                                                                        : (1 + OUT_REG_P);

  logic               in_range_c;
  logic               hit_c;
  logic [WIDTH_P-1:0] word_c;

  logic [WIDTH_P-1:0] data_q, data_d;
  logic               vld_q, vld_d;

  // Range check and write-through bypass select the word captured at the edge.
  always_comb begin
    in_range_c = ({1'b0, rd_addr_i} < DepthW);
    hit_c      = BypassEn && wr_en_i && (wr_addr_i == rd_addr_i);
    word_c     = '0;
    if (in_range_c) begin
      word_c = hit_c ? wr_data_i : mem_word_i;
    end
  end

  // First stage: capture only on an accepted read so the data holds otherwise.
  always_comb begin
    data_d = data_q;
    vld_d  = rd_en_i;
    if (rd_en_i) begin
      data_d = word_c;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  if (LatC == 2) begin : g_out_reg
    logic [WIDTH_P-1:0] out_data_q, out_data_d;
    logic               out_vld_q, out_vld_d;

    // Output stage follows the first stage one cycle later.
    always_comb begin
      out_data_d = out_data_q;
      out_vld_d  = vld_q;
      if (vld_q) begin
        out_data_d = data_q;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        out_data_q <= '0;
        out_vld_q  <= 1'b0;
      end else begin
        out_data_q <= out_data_d;
        out_vld_q  <= out_vld_d;
      end
    end

    assign rd_data_o  = out_data_q;
    assign rd_valid_o = out_vld_q;
  end else begin : g_no_out_reg
    assign rd_data_o  = data_q;
    assign rd_valid_o = vld_q;
  end

endmodule

// File: rtl/sync_ram_mport.sv
// Synchronous RAM with one write port, RD_PORTS_P read ports and a hardware
// clear sequencer that zeroes every word after reset or on clr_i.
//   clk_i, rst_i : clock, async active-high reset
//   clr_i        : request a full clear (accepted only when idle)
//   busy_o       : high while clearing; reads and writes ignored
//   wr_en_i, wr_addr_i, wr_data_i : write port
//   rd_en_i, rd_addr_i            : per-port read requests (packed)
//   rd_data_o, rd_valid_o         : per-port read results (packed)
module sync_ram_mport
  import sync_ram_pkg::*;
#(
  parameter int unsigned WIDTH_P    = 8,
  parameter int unsigned DEPTH_P    = 16,
  parameter int unsigned RD_PORTS_P = 3,
  parameter int unsigned RDW_MODE_P = 0,
  parameter int unsigned OUT_REG_P  = 0,
  parameter int unsigned AW_P       = $clog2(DEPTH_P)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clr_i,
  output logic                          busy_o,
  input  logic                          wr_en_i,
  input  logic [AW_P-1:0]               wr_addr_i,
  input  logic [WIDTH_P-1:0]            wr_data_i,
  input  logic [RD_PORTS_P-1:0]         rd_en_i,
  input  logic [RD_PORTS_P*AW_P-1:0]    rd_addr_i,
  output logic [RD_PORTS_P*WIDTH_P-1:0] rd_data_o,
  output logic [RD_PORTS_P-1:0]         rd_valid_o
);

  localparam logic [AW_P:0]   DepthW   = (AW_P+1)'(DEPTH_P);
  localparam logic [AW_P-1:0] LastAddr = AW_P'(DEPTH_P - 1);

  state_e             state_q, state_d;
  logic [AW_P-1:0]    cnt_q, cnt_d;
  logic               busy_q, busy_d;

  logic [WIDTH_P-1:0] mem_q [DEPTH_P];

  logic                  mem_we_c;
  logic [AW_P-1:0]       mem_waddr_c;
  logic [WIDTH_P-1:0]    mem_wdata_c;
  logic                  user_wr_c;
  logic [RD_PORTS_P-1:0] rd_go_c;

  // State, clear counter and busy flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Next state: sweep every address once, then idle until the next clear.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + AW_P'(1);
        if (cnt_q == LastAddr) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        if (clr_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: the clear sweep owns the write port; clr_i drops user traffic.
  always_comb begin
    busy_d      = (state_d == ST_CLEAR);
    mem_we_c    = 1'b0;
    mem_waddr_c = wr_addr_i;
    mem_wdata_c = wr_data_i;
    user_wr_c   = 1'b0;
    rd_go_c     = '0;
    case (state_q)
      ST_CLEAR: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = cnt_q;
        mem_wdata_c = '0;
      end
      ST_IDLE: begin
        if (!clr_i) begin
          user_wr_c = wr_en_i && ({1'b0, wr_addr_i} < DepthW);
          rd_go_c   = rd_en_i;
        end
        mem_we_c = user_wr_c;
      end
      default: begin
        mem_we_c = 1'b0;
      end
    endcase
  end

  assign busy_o = busy_q;

  // Storage array; contents are defined by the clear sweep, not by reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_c) begin
      mem_q[mem_waddr_c] <= mem_wdata_c;
    end
  end

  for (genvar p = 0; p < RD_PORTS_P; p++) begin : g_rd
    logic [AW_P-1:0]    addr_c;
    logic [WIDTH_P-1:0] word_c;

    assign addr_c = rd_addr_i[p*AW_P +: AW_P];

    // Guard the array index for depths that are not a power of two.
    always_comb begin
      word_c = '0;
      if ({1'b0, addr_c} < DepthW) begin
        word_c = mem_q[addr_c];
      end
    end

    sync_ram_rd_port #(
      .WIDTH_P   (WIDTH_P),
      .DEPTH_P   (DEPTH_P),
      .RDW_MODE_P(RDW_MODE_P),
      .OUT_REG_P (OUT_REG_P),
      .AW_P      (AW_P)
    ) u_rd_port (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .rd_en_i   (rd_go_c[p]),
      .rd_addr_i (addr_c),
      .mem_word_i(word_c),
      .wr_en_i   (user_wr_c),
      .wr_addr_i (wr_addr_i),
      .wr_data_i (wr_data_i),
      .rd_data_o (rd_data_o[p*WIDTH_P +: WIDTH_P]),
      .rd_valid_o(rd_valid_o[p])
    );
  end

endmodule

// File: tb/tb_sync_ram_mport.sv
// Scoreboard bench: two builds share one stimulus stream.
//   dut 0: DEPTH 16, old-data RDW, latency 1
//   dut 1: DEPTH 12, write-through RDW, latency 2
module tb_sync_ram_mport;

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        clr_i;
  logic        wr_en_i;
  logic [3:0]  wr_addr_i;
  logic [7:0]  wr_data_i;
  logic [2:0]  rd_en_i;
  logic [11:0] rd_addr_i;

  logic        busy_a, busy_b;
  logic [23:0] rdata_a, rdata_b;
  logic [2:0]  vld_a, vld_b;

  always #5 clk_i = ~clk_i;

  sync_ram_mport #(
    .WIDTH_P(8), .DEPTH_P(16), .RD_PORTS_P(3), .RDW_MODE_P(0), .OUT_REG_P(0)
  ) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .busy_o(busy_a),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i),
    .rd_data_o(rdata_a), .rd_valid_o(vld_a)
  );

  sync_ram_mport #(
    .WIDTH_P(8), .DEPTH_P(12), .RD_PORTS_P(3), .RDW_MODE_P(1), .OUT_REG_P(1)
  ) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .busy_o(busy_b),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i),
    .rd_data_o(rdata_b), .rd_valid_o(vld_b)
  );

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model, one slot per build.
  int         depth_m [2] = '{16, 12};
  int         lat_m   [2] = '{1, 2};
  bit         rdwn_m  [2] = '{1'b0, 1'b1};
  int         busy_left [2] = '{16, 12};
  logic [7:0] mmem [2][16];
  logic [7:0] last_d [2][3];
  exp_t       sbq [2][3][$];

  // Intended inputs for the next clock edge.
  logic       n_rst = 1'b1;
  logic       n_clr = 1'b0;
  logic       n_we  = 1'b0;
  logic [3:0] n_wa  = '0;
  logic [7:0] n_wd  = '0;
  logic [2:0] n_re  = '0;
  logic [3:0] n_ra [3] = '{4'd0, 4'd0, 4'd0};

  task automatic chk(input string nm, input int d, input int p,
                     input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d port%0d cyc%0d: got %0h expected %0h",
                  nm, d, p, cyc, act, exp);
  endtask

  function automatic logic [7:0] rdat(input int d, input int p);
    logic [23:0] v;
    v = (d == 0) ? rdata_a : rdata_b;
    return v[p*8 +: 8];
  endfunction

  function automatic logic rvld(input int d, input int p);
    logic [2:0] v;
    v = (d == 0) ? vld_a : vld_b;
    return v[p];
  endfunction

  function automatic logic rbusy(input int d);
    return (d == 0) ? busy_a : busy_b;
  endfunction

  task automatic zero_model(input int d);
    for (int a = 0; a < 16; a++) mmem[d][a] = 8'h00;
  endtask

  // Drive one cycle at the falling edge and predict the next rising edge.
  task automatic tick();
    logic rst_prev;
    @(negedge clk_i);
    for (int d = 0; d < 2; d++) chk("busy", d, 0, 32'(rbusy(d)), 32'(busy_left[d] > 0));
    rst_prev  = rst_i;
    rst_i     = n_rst;
    clr_i     = n_clr;
    wr_en_i   = n_we;
    wr_addr_i = n_wa;
    wr_data_i = n_wd;
    rd_en_i   = n_re;
    rd_addr_i = {n_ra[2], n_ra[1], n_ra[0]};
    if (n_rst) begin
      for (int d = 0; d < 2; d++) begin
        busy_left[d] = depth_m[d];
        zero_model(d);
        for (int p = 0; p < 3; p++) sbq[d][p].delete();
      end
      if (!rst_prev) begin
        #1;
        for (int d = 0; d < 2; d++) begin
          chk("rst_busy", d, 0, 32'(rbusy(d)), 32'd1);
          for (int p = 0; p < 3; p++) begin
            chk("rst_vld", d, p, 32'(rvld(d, p)), 32'd0);
            chk("rst_data", d, p, 32'(rdat(d, p)), 32'd0);
          end
        end
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        bit   busy_now;
        bit   weff;
        exp_t e;
        busy_now = busy_left[d] > 0;
        weff = !busy_now && !n_clr && n_we && (int'(n_wa) < depth_m[d]);
        if (!busy_now && !n_clr) begin
          for (int p = 0; p < 3; p++) begin
            if (n_re[p]) begin
              e.due = cyc + lat_m[d];
              if (int'(n_ra[p]) >= depth_m[d]) e.data = 8'h00;
              else if (rdwn_m[d] && weff && (n_wa == n_ra[p])) e.data = n_wd;
              else e.data = mmem[d][n_ra[p]];
              sbq[d][p].push_back(e);
            end
          end
        end
        if (weff) mmem[d][n_wa] = n_wd;
        if (busy_now) busy_left[d]--;
        else if (n_clr) begin
          busy_left[d] = depth_m[d];
          zero_model(d);
        end
      end
    end
    n_clr = 1'b0;
    n_we  = 1'b0;
    n_re  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_wr(input logic [3:0] a, input logic [7:0] dt);
    n_we = 1'b1; n_wa = a; n_wd = dt;
    tick();
  endtask

  task automatic do_rd(input logic [2:0] re, input logic [3:0] a0,
                       input logic [3:0] a1, input logic [3:0] a2);
    n_re = re; n_ra[0] = a0; n_ra[1] = a1; n_ra[2] = a2;
    tick();
  endtask

  // Monitor: pops the scoreboard whenever a port presents valid data.
  always @(posedge clk_i) begin
    #2;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 3; p++) begin
        exp_t e;
        if (rst_i) begin
          last_d[d][p] = 8'h00;
          chk("rst_hold_vld", d, p, 32'(rvld(d, p)), 32'd0);
          chk("rst_hold_data", d, p, 32'(rdat(d, p)), 32'd0);
        end else if (rvld(d, p)) begin
          if (sbq[d][p].size() == 0) begin
            chk("rd_unexpected", d, p, 32'd1, 32'd0);
          end else begin
            e = sbq[d][p].pop_front();
            chk("rd_due", d, p, 32'(cyc), 32'(e.due));
            chk("rd_data", d, p, 32'(rdat(d, p)), 32'(e.data));
            last_d[d][p] = e.data;
          end
        end else begin
          if (sbq[d][p].size() > 0 && sbq[d][p][0].due <= cyc) begin
            chk("rd_missing", d, p, 32'd0, 32'd1);
            e = sbq[d][p].pop_front();
          end
          chk("rd_hold", d, p, 32'(rdat(d, p)), 32'(last_d[d][p]));
        end
      end
    end
  end

  initial begin
    rst_i = 1'b1; clr_i = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0;
    wr_data_i = '0; rd_en_i = '0; rd_addr_i = '0;
    for (int d = 0; d < 2; d++) begin
      zero_model(d);
      for (int p = 0; p < 3; p++) last_d[d][p] = 8'h00;
    end

    // Reset, then release with all read enables held high through the clear.
    n_rst = 1'b1;
    idle(2);
    n_rst = 1'b0;
    for (int i = 0; i < 20; i++) do_rd(3'b111, 4'd0, 4'd5, 4'd15);
    idle(3);

    // Basic write then three-port read.
    do_wr(4'd0, 8'd42);
    do_wr(4'd15, 8'hFF);
    do_rd(3'b111, 4'd0, 4'd15, 4'd15);
    idle(3);

    // Same-address read during write, then a plain re-read.
    do_wr(4'd0, 8'd7);
    n_we = 1'b1; n_wa = 4'd0; n_wd = 8'd13;
    do_rd(3'b001, 4'd0, 4'd0, 4'd0);
    do_rd(3'b001, 4'd0, 4'd0, 4'd0);
    idle(3);

    // Fill all words, then stream reads at staggered addresses.
    for (int i = 0; i < 16; i++) do_wr(4'(i), 8'(i * 37 + 5));
    for (int i = 0; i < 16; i++)
      do_rd(3'b111, 4'(i), 4'((i + 5) % 16), 4'((i + 10) % 16));
    idle(3);

    // Clear request drops a simultaneous write and reads.
    do_wr(4'd3, 8'd55);
    n_clr = 1'b1; n_we = 1'b1; n_wa = 4'd4; n_wd = 8'd99;
    do_rd(3'b111, 4'd3, 4'd4, 4'd3);
    idle(17);
    do_rd(3'b111, 4'd3, 4'd4, 4'd3);
    idle(3);

    // Reset in the middle of a clear, then out-of-range accesses.
    do_wr(4'd2, 8'hA5);
    do_rd(3'b111, 4'd2, 4'd2, 4'd2);
    idle(2);
    n_clr = 1'b1;
    tick();
    idle(8);
    n_rst = 1'b1;
    idle(2);
    n_rst = 1'b0;
    idle(18);
    do_wr(4'd13, 8'd77);
    do_rd(3'b011, 4'd13, 4'd12, 4'd0);
    idle(6);

    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 3; p++)
        chk("sb_empty", d, p, 32'(sbq[d][p].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sync_ram_mport.md
Name: sync_ram_mport

Overview:
Parametrised successor to the two-read-port sync RAM used by the Sobel line buffers. It provides one write port and RD_PORTS_P independent synchronous read ports. Each read port has a valid flag, a selectable read-during-write mode and an optional output register stage. A hardware clear sequencer zeroes every word after reset or on request, so line buffers start from known data without a bench preload. It sits under the window/line-buffer logic and feeds the 3x3 kernel taps.

Parameters:
WIDTH_P, 8, data word width in bits
DEPTH_P, 16, number of words; need not be a power of two
RD_PORTS_P, 3, number of read ports, range 1..8
RDW_MODE_P, 0, same-address read-during-write result: 0 = old data, 1 = new (write-through) data
OUT_REG_P, 0, 1 adds an output register, so read latency becomes 2 instead of 1
AW_P, $clog2(DEPTH_P), derived address width; not to be overridden

Ports:
clk_i  in  1  clock; all logic on posedge
rst_i  in  1  asynchronous, active-high reset
clr_i  in  1  request a full memory clear (one-cycle pulse or level)
busy_o  out  1  high while clearing; writes and reads are ignored
wr_en_i  in  1  write enable
wr_addr_i  in  AW_P  write address
wr_data_i  in  WIDTH_P  write data
rd_en_i  in  RD_PORTS_P  per-port read enable
rd_addr_i  in  RD_PORTS_P*AW_P  packed read addresses; port p occupies bits [p*AW_P +: AW_P]
rd_data_o  out  RD_PORTS_P*WIDTH_P  packed read data, same packing as rd_addr_i
rd_valid_o  out  RD_PORTS_P  per-port data-valid strobe

Behaviour:
- Reset (async assert): state=ST_CLEAR, clear counter=0, busy_o=1, rd_data_o=0, rd_valid_o=0, output pipe registers=0.
- Memory array itself is not reset.
- Reset asserted mid-clear restarts the clear from address 0.
- ST_CLEAR:
  - Writes 0 to address = counter each cycle; counter runs 0..DEPTH_P-1.
  - Leaves for ST_IDLE after writing address DEPTH_P-1, so busy_o is high for exactly DEPTH_P cycles after reset release.
  - wr_en_i, rd_en_i and clr_i are ignored; rd_valid_o=0; rd_data_o holds its value.
- ST_IDLE:
  - clr_i=1 moves to ST_CLEAR on the next edge, with the counter set to 0.
  - clr_i has priority: a wr_en_i or rd_en_i in the same cycle is dropped.
  - busy_o rises the cycle after clr_i is sampled.
- Write: when wr_en_i=1 and wr_addr_i<DEPTH_P, mem[wr_addr_i]<=wr_data_i at the edge. An out-of-range address is silently dropped.
- Read port p (latency L = 1+OUT_REG_P):
  - rd_en_i[p] sampled at edge N makes rd_valid_o[p]=1 after edge N+L-1, for one cycle per accepted enable.
  - Back-to-back enables give continuous valid and full throughput.
  - rd_data_o[p] holds its last value while no read is in flight.
  - Out-of-range address returns 0, with valid still asserted.
- Read-during-write: same address in the same cycle as a write.
  - RDW_MODE_P=0: returns the pre-write word.
  - RDW_MODE_P=1: returns wr_data_i.
  - Different addresses are unaffected.
- Any number of ports may read the same address in the same cycle; all return identical data.
- Clear write and user write are never simultaneous (the FSM gates them).

Decomposition:
- Package sync_ram_pkg holds:
  - typedef enum state_e {ST_CLEAR, ST_IDLE}
  - typedef enum rdw_mode_e {RDW_OLD=0, RDW_NEW=1}
  - localparam OUT_LAT_MAX=2
- Sub-module sync_ram_rd_port is generated RD_PORTS_P times. Each instance contains the address/enable capture, range check, RDW bypass mux, optional output register and valid pipe.
- The top module holds the memory array, the clear FSM/counter and the write path.

Test Plan:
1. Release reset with rd_en_i=3'b111 held high -> busy_o stays 1 for exactly 16 cycles and rd_valid_o=0 throughout. After that, reading addresses 0, 5, 15 returns 8'h00 with valid one cycle later.
2. Write 8'd42@0 and 8'hFF@15. Then in one cycle read port0@0, port1@15, port2@15 -> next cycle data 42/FF/FF and rd_valid_o=3'b111. With OUT_REG_P=1, the same data and valid appear one cycle later.
3. Preload 8'd7@0, then same cycle wr 8'd13@0 with port0 reading @0 -> RDW_MODE_P=0 gives 7, RDW_MODE_P=1 gives 13. A following read gives 13 in both builds.
4. Fill 16 random words, then stream reads with rd_en held for 16 cycles on all ports at staggered addresses -> every valid cycle matches the scoreboard and valid is continuous.
5. Write 8'd55@3, then pulse clr_i together with wr 8'd99@4 -> busy_o high for 16 cycles. Afterwards @3 reads 0 and @4 reads 0 (write dropped).
6. Assert rst_i at clear cycle 8 for 2 cycles -> outputs zero immediately and busy_o is high for a full 16 cycles after release. With DEPTH_P=12, a write to address 13 is dropped and a read of address 13 returns 0 with valid=1.
